// File: rtl/spi_input_conditioner.sv
// spi_input_conditioner
// Front end for the SPI slave. Brings the raw sclk, cs and mosi pins into the
// clk domain through two-flop synchronizers, debounces each channel with a
// saturating counter, and derives registered single-cycle edge pulses plus
// the MOSI bit captured on every debounced SCLK rise.
module spi_input_conditioner #(
  parameter int COUNTER_WIDTH = 3,
  parameter int WAIT_TIME     = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sclk_pin,
  input  logic cs_pin,
  input  logic mosi_pin,
  output logic sclk_cond,
  output logic sclk_posedge,
  output logic sclk_negedge,
  output logic cs_cond,
  output logic cs_fall,
  output logic cs_rise,
  output logic mosi_cond,
  output logic mosi_sample
);

  // Channel indices into the per-channel vectors below.
  localparam int CH_SCLK = 0;
  localparam int CH_CS   = 1;
  localparam int CH_MOSI = 2;

  // Idle levels: SCLK low, CS high (deselected), MOSI low.
  localparam logic [2:0] RST_LVL = 3'b010;

  localparam logic [COUNTER_WIDTH-1:0] WAIT_CNT = COUNTER_WIDTH'(WAIT_TIME);
  localparam logic [COUNTER_WIDTH-1:0] CNT_ONE  = COUNTER_WIDTH'(1);

  logic [2:0]               w_pin;
  logic [2:0]               r_sync0;
  logic [2:0]               r_sync1;
  logic [2:0]               r_cond;
  logic [COUNTER_WIDTH-1:0] r_cnt [3];
  logic [2:0]               w_accept;

  logic r_sclk_posedge;
  logic r_sclk_negedge;
  logic r_cs_fall;
  logic r_cs_rise;
  logic r_mosi_sample;

  assign w_pin = {mosi_pin, cs_pin, sclk_pin};

  // A channel accepts the synchronized level once it has disagreed with the
  // conditioned level for WAIT_TIME+1 consecutive samples.
  always_comb begin
    // NOTE: every bit gets a value on every pass through always_comb, so no
    // latch can be inferred.
    w_accept = '0;
    for (int i = 0; i < 3; i++) begin
      w_accept[i] = (r_sync1[i] != r_cond[i]) && (r_cnt[i] == WAIT_CNT);
    end
  end

  // Two-flop synchronizers for the asynchronous pins.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge values of the others, exactly like hardware.
    if (!rst_n) begin
      r_sync0 <= RST_LVL;
      r_sync1 <= RST_LVL;
    end else begin
      r_sync0 <= w_pin;
      r_sync1 <= r_sync0;
    end
  end

  // Debounce counters and conditioned levels.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cond <= RST_LVL;
      // NOTE: the counter array is reset explicitly; it is three tiny
      // registers, not a RAM, and a mid-frame reset must not leave a
      // half-counted glitch behind.
      for (int i = 0; i < 3; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (r_sync1[i] == r_cond[i]) begin
          r_cnt[i] <= '0;
        end else if (w_accept[i]) begin
          r_cond[i] <= r_sync1[i];
          r_cnt[i]  <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + CNT_ONE;
        end
      end
    end
  end

  // Edge pulses, asserted on the same edge the conditioned level changes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sclk_posedge <= 1'b0;
      r_sclk_negedge <= 1'b0;
      r_cs_fall      <= 1'b0;
      r_cs_rise      <= 1'b0;
    end else begin
      r_sclk_posedge <= w_accept[CH_SCLK] &  r_sync1[CH_SCLK];
      r_sclk_negedge <= w_accept[CH_SCLK] & ~r_sync1[CH_SCLK];
      r_cs_fall      <= w_accept[CH_CS]   & ~r_sync1[CH_CS];
      r_cs_rise      <= w_accept[CH_CS]   &  r_sync1[CH_CS];
    end
  end

  // MOSI capture on the debounced SCLK rise; reads the pre-edge mosi level
  // so a simultaneous MOSI update is not seen until the next rise.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mosi_sample <= 1'b0;
    end else if (w_accept[CH_SCLK] && r_sync1[CH_SCLK]) begin
      r_mosi_sample <= r_cond[CH_MOSI];
    end
  end

  assign sclk_cond    = r_cond[CH_SCLK];
  assign cs_cond      = r_cond[CH_CS];
  assign mosi_cond    = r_cond[CH_MOSI];
  assign sclk_posedge = r_sclk_posedge;
  assign sclk_negedge = r_sclk_negedge;
  assign cs_fall      = r_cs_fall;
  assign cs_rise      = r_cs_rise;
  assign mosi_sample  = r_mosi_sample;

endmodule

// File: tb/tb_spi_input_conditioner.sv
// tb_spi_input_conditioner
// Directed bench for spi_input_conditioner. A window-based model of the
// debounce rule runs alongside the DUT and is compared every cycle; the
// directed sequences also pin latencies and captured bits to literal values.
module tb_spi_input_conditioner;

  localparam int W    = 3;
  localparam int MAXE = 4096;
  localparam logic [2:0] RST_LVL = 3'b010;  // {mosi, cs, sclk}

  // Output selectors for get_out().
  localparam int O_SPOS  = 0;
  localparam int O_SNEG  = 1;
  localparam int O_CFALL = 2;
  localparam int O_CRISE = 3;

  logic clk      = 1'b0;
  logic rst_n    = 1'b0;
  logic sclk_pin = 1'b0;
  logic cs_pin   = 1'b1;
  logic mosi_pin = 1'b0;

  logic sclk_cond, sclk_posedge, sclk_negedge;
  logic cs_cond, cs_fall, cs_rise;
  logic mosi_cond, mosi_sample;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b1;

  spi_input_conditioner #(.COUNTER_WIDTH(3), .WAIT_TIME(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sclk_pin     (sclk_pin),
    .cs_pin       (cs_pin),
    .mosi_pin     (mosi_pin),
    .sclk_cond    (sclk_cond),
    .sclk_posedge (sclk_posedge),
    .sclk_negedge (sclk_negedge),
    .cs_cond      (cs_cond),
    .cs_fall      (cs_fall),
    .cs_rise      (cs_rise),
    .mosi_cond    (mosi_cond),
    .mosi_sample  (mosi_sample)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------
  // Model: a level is accepted when the last W+1 synchronized samples all
  // disagree with the conditioned level and none of them predates the last
  // level change (or reset).
  // ---------------------------------------------------------------------
  int       edge_n = 0;
  logic     m_win [3][MAXE];
  int       m_last [3];
  logic [2:0] m_s0   = RST_LVL;
  logic [2:0] m_s1   = RST_LVL;
  logic [2:0] m_cond = RST_LVL;
  logic m_spos = 1'b0, m_sneg = 1'b0, m_cfall = 1'b0, m_crise = 1'b0;
  logic m_sample = 1'b0;

  task automatic model_step();
    logic [2:0] pins;
    logic [2:0] nc;
    logic [2:0] acc;
    bit         all_diff;
    pins = {mosi_pin, cs_pin, sclk_pin};
    if (!rst_n) begin
      m_s0 = RST_LVL;
      m_s1 = RST_LVL;
      m_cond = RST_LVL;
      for (int c = 0; c < 3; c++) m_last[c] = edge_n;
      m_spos = 1'b0; m_sneg = 1'b0; m_cfall = 1'b0; m_crise = 1'b0;
      m_sample = 1'b0;
    end else begin
      nc  = m_cond;
      acc = '0;
      for (int c = 0; c < 3; c++) begin
        m_win[c][edge_n % MAXE] = m_s1[c];
        if (edge_n - m_last[c] >= W + 1) begin
          all_diff = 1'b1;
          for (int j = 0; j <= W; j++)
            if (m_win[c][(edge_n - j) % MAXE] == m_cond[c]) all_diff = 1'b0;
          if (all_diff) begin
            acc[c]    = 1'b1;
            nc[c]     = m_s1[c];
            m_last[c] = edge_n;
          end
        end
      end
      m_spos  = acc[0] &  nc[0];
      m_sneg  = acc[0] & ~nc[0];
      m_cfall = acc[1] & ~nc[1];
      m_crise = acc[1] &  nc[1];
      if (acc[0] && nc[0]) m_sample = m_cond[2];
      m_cond = nc;
      m_s1   = m_s0;
      m_s0   = pins;
    end
    edge_n++;
  endtask

  initial begin
    for (int c = 0; c < 3; c++) m_last[c] = 0;
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  // Per-cycle compare against the model, plus pulse counters.
  int pc_spos = 0, pc_sneg = 0, pc_cfall = 0, pc_crise = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (sclk_posedge === 1'b1) pc_spos++;
      if (sclk_negedge === 1'b1) pc_sneg++;
      if (cs_fall === 1'b1)      pc_cfall++;
      if (cs_rise === 1'b1)      pc_crise++;
      if (cmp_en) begin
        check("sclk_cond",    sclk_cond,    m_cond[0]);
        check("cs_cond",      cs_cond,      m_cond[1]);
        check("mosi_cond",    mosi_cond,    m_cond[2]);
        check("sclk_posedge", sclk_posedge, m_spos);
        check("sclk_negedge", sclk_negedge, m_sneg);
        check("cs_fall",      cs_fall,      m_cfall);
        check("cs_rise",      cs_rise,      m_crise);
        check("mosi_sample",  mosi_sample,  m_sample);
      end
    end
  end

  function automatic logic get_out(input int w);
    case (w)
      O_SPOS:  return sclk_posedge;
      O_SNEG:  return sclk_negedge;
      O_CFALL: return cs_fall;
      default: return cs_rise;
    endcase
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Counts sampled cycles until the chosen pulse shows, bounded by limit.
  task automatic edges_until(input int w, input int limit, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (get_out(w) !== 1'b1 && n < limit);
  endtask

  // ---------------------------------------------------------------------
  // Directed stimulus
  // ---------------------------------------------------------------------
  initial begin
    int n;
    int s_pos, s_neg;
    logic [7:0] tx_byte;

    // Reset held with pins toggling: outputs stay at their idle levels.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("rst_cs_cond",   cs_cond,   1'b1);
      check("rst_sclk_cond", sclk_cond, 1'b0);
      check("rst_pulses", {sclk_posedge, sclk_negedge, cs_fall, cs_rise}, 4'b0);
      check("rst_mosi_sample", mosi_sample, 1'b0);
      sclk_pin = i[0];
      cs_pin   = i[1];
      mosi_pin = i[2];
    end

    // Release with CS asserted: one cs_fall on the 6th edge.
    @(negedge clk);
    rst_n = 1'b1; cs_pin = 1'b0; sclk_pin = 1'b0; mosi_pin = 1'b0;
    s_pos = pc_cfall;
    edges_until(O_CFALL, 20, n);
    check("cs_fall_latency", n, 6);
    check("cs_cond_low", cs_cond, 1'b0);
    tick(1);
    check("cs_fall_one_cycle", cs_fall, 1'b0);
    tick(8);
    check("cs_fall_count", pc_cfall - s_pos, 1);

    // Clean SCLK rise then fall, 10 cycles each.
    s_pos = pc_spos; s_neg = pc_sneg;
    sclk_pin = 1'b1;
    edges_until(O_SPOS, 20, n);
    check("sclk_pos_latency", n, 6);
    check("sclk_cond_high", sclk_cond, 1'b1);
    tick(4);
    sclk_pin = 1'b0;
    edges_until(O_SNEG, 20, n);
    check("sclk_neg_latency", n, 6);
    check("sclk_cond_low", sclk_cond, 1'b0);
    tick(6);
    check("clean_pos_count", pc_spos - s_pos, 1);
    check("clean_neg_count", pc_sneg - s_neg, 1);

    // Glitch: 3-cycle high is rejected.
    s_pos = pc_spos; s_neg = pc_sneg;
    sclk_pin = 1'b1; tick(3);
    sclk_pin = 1'b0; tick(12);
    check("glitch3_pos", pc_spos - s_pos, 0);
    check("glitch3_neg", pc_sneg - s_neg, 0);
    check("glitch3_cond", sclk_cond, 1'b0);

    // 4-cycle high is accepted: one rise, one fall.
    s_pos = pc_spos; s_neg = pc_sneg;
    sclk_pin = 1'b1; tick(4);
    sclk_pin = 1'b0; tick(14);
    check("pulse4_pos", pc_spos - s_pos, 1);
    check("pulse4_neg", pc_sneg - s_neg, 1);
    check("pulse4_cond", sclk_cond, 1'b0);

    // MOSI byte 0xA5 MSB first, 8 cycles setup, 10-cycle SCLK half-period.
    tx_byte = 8'hA5;
    for (int b = 7; b >= 0; b--) begin
      mosi_pin = tx_byte[b];
      tick(8);
      sclk_pin = 1'b1;
      edges_until(O_SPOS, 20, n);
      check("byte_pos_latency", n, 6);
      check("byte_bit", mosi_sample, tx_byte[b]);
      tick(4);
      sclk_pin = 1'b0;
      tick(2);
    end
    mosi_pin = 1'b0;
    tick(10);

    // Simultaneous MOSI and SCLK rise: old MOSI (0) is captured.
    check("simul_pre_mosi", mosi_cond, 1'b0);
    mosi_pin = 1'b1; sclk_pin = 1'b1;
    edges_until(O_SPOS, 20, n);
    check("simul_latency", n, 6);
    check("simul_sample", mosi_sample, 1'b0);
    check("simul_mosi_cond", mosi_cond, 1'b1);
    tick(4);
    sclk_pin = 1'b0;
    tick(10);

    // Mid-frame reset for one cycle, then the frame restarts.
    sclk_pin = 1'b1;
    tick(3);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_cs", cs_cond, 1'b1);
    check("mid_rst_sclk", sclk_cond, 1'b0);
    check("mid_rst_mosi", mosi_cond, 1'b0);
    check("mid_rst_pulses", {sclk_posedge, sclk_negedge, cs_fall, cs_rise}, 4'b0);
    check("mid_rst_sample", mosi_sample, 1'b0);
    rst_n = 1'b1;
    edges_until(O_CFALL, 20, n);
    check("restart_cs_fall", n, 6);
    check("restart_sclk_pos", sclk_posedge, 1'b1);
    check("restart_sample", mosi_sample, 1'b0);
    tick(2);
    cs_pin = 1'b1;
    edges_until(O_CRISE, 20, n);
    check("cs_rise_latency", n, 6);
    check("cs_cond_high", cs_cond, 1'b1);
    tick(4);

    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
